// File: rtl/data_ram_ctrl.sv
// Byte-addressable data RAM controller with a valid/ready request port and
// registered responses. Word-crossing accesses either split over two cycles
// or are rejected with rsp_err, depending on ALLOW_UNAL.
module data_ram_ctrl #(
  parameter int AW         = 10,
  parameter bit ALLOW_UNAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_mask,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int WW    = AW - 2;
  localparam int DEPTH = 1 << WW;

  typedef enum logic {IDLE, SPLIT} state_t;

  logic [31:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [WW-1:0]   w1_q, w1_d;
  logic [1:0]      o_q, o_d;
  logic [2:0]      n_q, n_d;
  logic            sgn_q, sgn_d;
  logic            we_q, we_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     wd_hi_q, wd_hi_d;
  logic [3:0]      be_hi_q, be_hi_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic            mem_we;
  logic [WW-1:0]   mem_addr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_be;

  logic [WW-1:0]   a_w0, a_w1;
  logic [1:0]      a_o;
  logic [2:0]      a_n;
  logic            a_cross;
  logic [7:0]      a_be64;
  logic [63:0]     a_wd64;
  logic [63:0]     rd64;
  logic            accept;

  // Address bits above AW are intentionally ignored (address wraps).
  logic unused_addr;
  assign unused_addr = &{1'b0, req_addr[31:AW]};

  // Shift the selected bytes down to lane 0 and apply size / sign extension.
  function automatic logic [31:0] assemble(input logic [63:0] rd, input logic [1:0] o,
                                           input logic [2:0] n, input logic sgn);
    logic [31:0] raw;
    raw = 32'(rd >> {o, 3'b000});
    case (n)
      3'd4:    assemble = raw;
      3'd2:    assemble = {{16{raw[15] & sgn}}, raw[15:0]};
      default: assemble = {{24{raw[7] & sgn}}, raw[7:0]};
    endcase
  endfunction

  // Request decode, next-state and memory-port control.
  always_comb begin
    state_d     = state_q;
    w1_d        = w1_q;
    o_d         = o_q;
    n_d         = n_q;
    sgn_d       = sgn_q;
    we_d        = we_q;
    lo_d        = lo_q;
    wd_hi_d     = wd_hi_q;
    be_hi_d     = be_hi_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_be      = '0;

    a_w0    = req_addr[AW-1:2];
    a_w1    = a_w0 + WW'(1);
    a_o     = req_addr[1:0];
    a_n     = req_mask[1] ? 3'd4 : (req_mask[0] ? 3'd2 : 3'd1);
    a_cross = ({2'b00, a_o} + {1'b0, a_n}) > 4'd4;
    a_be64  = (req_mask[1] ? 8'h0F : (req_mask[0] ? 8'h03 : 8'h01)) << a_o;
    a_wd64  = {32'h0, req_wdata} << {a_o, 3'b000};
    rd64    = {mem[a_w1], mem[a_w0]};

    req_ready = (state_q == IDLE);
    accept    = req_valid & req_ready;

    if (state_q == IDLE) begin
      if (accept) begin
        if (!a_cross) begin
          mem_we      = req_we;
          mem_addr    = a_w0;
          mem_wdata   = a_wd64[31:0];
          mem_be      = a_be64[3:0];
          rsp_valid_d = 1'b1;
          rsp_rdata_d = req_we ? 32'h0 : assemble(rd64, a_o, a_n, req_signed);
        end else if (ALLOW_UNAL) begin
          mem_we    = req_we;
          mem_addr  = a_w0;
          mem_wdata = a_wd64[31:0];
          mem_be    = a_be64[3:0];
          lo_d      = mem[a_w0];
          w1_d      = a_w1;
          o_d       = a_o;
          n_d       = a_n;
          sgn_d     = req_signed;
          we_d      = req_we;
          wd_hi_d   = a_wd64[63:32];
          be_hi_d   = a_be64[7:4];
          state_d   = SPLIT;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end
      end
    end else begin
      // Second half of a crossing access: upper lanes live in the next word.
      rd64        = {mem[w1_q], lo_q};
      mem_we      = we_q;
      mem_addr    = w1_q;
      mem_wdata   = wd_hi_q;
      mem_be      = be_hi_q;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = we_q ? 32'h0 : assemble(rd64, o_q, n_q, sgn_q);
      state_d     = IDLE;
    end

    // No write may land while reset is held (aborted split leaves word 1 untouched).
    mem_we = mem_we & rst_n;
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w1_q        <= '0;
      o_q         <= '0;
      n_q         <= '0;
      sgn_q       <= 1'b0;
      we_q        <= 1'b0;
      lo_q        <= '0;
      wd_hi_q     <= '0;
      be_hi_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      w1_q        <= w1_d;
      o_q         <= o_d;
      n_q         <= n_d;
      sgn_q       <= sgn_d;
      we_q        <= we_d;
      lo_q        <= lo_d;
      wd_hi_q     <= wd_hi_d;
      be_hi_q     <= be_hi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage with per-byte write enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
